// File: rtl/logc_pipe_mc.sv
// Multi-channel piecewise-linear log2 compressor with gain/offset saturation and linear bypass.
// Three-stage valid/ready pipeline (LOD -> multiply -> offset/saturate) that stalls as a whole.
module logc_pipe_mc #(
  parameter int DATA_WIDTH = 48,
  parameter int COMP_WIDTH = 24,
  parameter int NUM_CH     = 4,
  parameter int FRAC_BITS  = 8,
  parameter int GAIN_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic                         mode,
  input  logic [GAIN_WIDTH-1:0]        gain,
  input  logic [COMP_WIDTH-1:0]        offset,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*COMP_WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]            out_sat
);

  localparam int EW  = $clog2(DATA_WIDTH);
  localparam int LW  = EW + FRAC_BITS;
  localparam int PW  = LW + GAIN_WIDTH;
  localparam int SW  = ((PW > COMP_WIDTH) ? PW : COMP_WIDTH) + 2;
  localparam int BW  = (DATA_WIDTH > COMP_WIDTH) ? DATA_WIDTH : COMP_WIDTH;
  localparam int BSH = (DATA_WIDTH > COMP_WIDTH) ? DATA_WIDTH - COMP_WIDTH : 0;

  // {exponent, left-aligned mantissa}; a zero sample naturally yields 0.
  function automatic logic [LW-1:0] log2_pwl(input logic [DATA_WIDTH-1:0] x);
    logic [EW-1:0]         e;
    logic [DATA_WIDTH-1:0] norm;
    e = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (x[i]) e = EW'(i);
    norm = x << (DATA_WIDTH - 1 - int'(e));
    return {e, FRAC_BITS'(norm >> (DATA_WIDTH - 1 - FRAC_BITS))};
  endfunction

  function automatic logic [COMP_WIDTH-1:0] bypass(input logic [DATA_WIDTH-1:0] x);
    return COMP_WIDTH'(BW'(x) >> BSH);
  endfunction

  // Returns {sat, value}: clamps P - offset into [0, 2^COMP_WIDTH-1].
  function automatic logic [COMP_WIDTH:0] sat_sub(input logic [PW-1:0] p,
                                                  input logic [COMP_WIDTH-1:0] off);
    logic signed [SW-1:0] d;
    logic signed [SW-1:0] max_v;
    d     = $signed(SW'(p)) - $signed(SW'(off));
    max_v = $signed(SW'({COMP_WIDTH{1'b1}}));
    if (d < 0)          return {1'b1, {COMP_WIDTH{1'b0}}};
    else if (d > max_v) return {1'b1, {COMP_WIDTH{1'b1}}};
    else                return {1'b0, d[COMP_WIDTH-1:0]};
  endfunction

  logic                  en;
  logic                  vld_p0, vld_p1, vld_p2;
  logic                  mode_p0, mode_p1;
  logic [GAIN_WIDTH-1:0] gain_p0;
  logic [COMP_WIDTH-1:0] off_p0, off_p1;
  logic [NUM_CH-1:0]     zero_p0, zero_p1;
  logic [LW-1:0]         l_p0   [NUM_CH];
  logic [COMP_WIDTH-1:0] byp_p0 [NUM_CH];
  logic [COMP_WIDTH-1:0] byp_p1 [NUM_CH];
  logic [PW-1:0]         p_p1   [NUM_CH];
  logic [COMP_WIDTH:0]   res    [NUM_CH];

  assign en        = !vld_p2 | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      // S1: leading-one detect / normalise, config captured with the beat
      mode_p0 <= mode;
      gain_p0 <= gain;
      off_p0  <= offset;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        l_p0[ch]    <= log2_pwl(in_data[ch*DATA_WIDTH +: DATA_WIDTH]);
        byp_p0[ch]  <= bypass(in_data[ch*DATA_WIDTH +: DATA_WIDTH]);
        zero_p0[ch] <= (in_data[ch*DATA_WIDTH +: DATA_WIDTH] == '0);
      end
      // S2: exact log-domain gain
      mode_p1 <= mode_p0;
      off_p1  <= off_p0;
      zero_p1 <= zero_p0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        byp_p1[ch] <= byp_p0[ch];
        p_p1[ch]   <= PW'(l_p0[ch]) * PW'(gain_p0);
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      res[ch] = '0;
      if (mode_p1)          res[ch] = {1'b0, byp_p1[ch]};
      else if (!zero_p1[ch]) res[ch] = sat_sub(p_p1[ch], off_p1);
    end
  end

  // S3: offset / saturate into the output register
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_sat  <= '0;
    end else if (en) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        out_data[ch*COMP_WIDTH +: COMP_WIDTH] <= res[ch][COMP_WIDTH-1:0];
        out_sat[ch]                           <= res[ch][COMP_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_logc_pipe_mc.sv
// Scoreboard bench for logc_pipe_mc: a 24-bit-output instance (a) and a 16-bit-output instance (b).
module tb_logc_pipe_mc;

  typedef logic [3:0][47:0] xv_t;
  typedef logic [3:0][23:0] yv_t;
  typedef struct {
    yv_t        d;
    logic [3:0] s;
    int         cyc;
    bit         lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid_a, in_ready_a, mode_a, out_valid_a, out_ready_a;
  logic [191:0] in_data_a;
  logic [7:0]   gain_a;
  logic [23:0]  offset_a;
  logic [95:0]  out_data_a;
  logic [3:0]   out_sat_a;

  logic         in_valid_b, in_ready_b, mode_b, out_valid_b, out_ready_b;
  logic [191:0] in_data_b;
  logic [7:0]   gain_b;
  logic [15:0]  offset_b;
  logic [63:0]  out_data_b;
  logic [3:0]   out_sat_b;

  logc_pipe_mc #(.COMP_WIDTH(24)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .mode(mode_a), .gain(gain_a), .offset(offset_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a), .out_sat(out_sat_a)
  );

  logc_pipe_mc #(.COMP_WIDTH(16)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .mode(mode_b), .gain(gain_b), .offset(offset_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .out_sat(out_sat_b)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready
  exp_t qa[$];
  exp_t qb[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Independent reference: mantissa from (x - 2^e) scaled by 256/2^e.
  function automatic void model(input logic [47:0] x, input bit md, input int g, input int off,
                                input int cw, output logic [23:0] y, output logic s);
    int     e;
    longint m, p, d, mx;
    y  = '0;
    s  = 1'b0;
    mx = (longint'(1) << cw) - 1;
    if (md) begin
      y = 24'(x >> (48 - cw));
      return;
    end
    if (x == 0) return;
    e = 47;
    while (!x[e]) e--;
    m = ((longint'(x) - (longint'(1) << e)) * 256) >> e;
    p = (longint'(e) * 256 + m) * g;
    d = p - off;
    if (d < 0) begin
      y = '0; s = 1'b1;
    end else if (d > mx) begin
      y = 24'(mx); s = 1'b1;
    end else begin
      y = 24'(d);
    end
  endfunction

  task automatic set_rdy();
    case (rdy_mode)
      0:       out_ready_a = 1'b1;
      1:       out_ready_a = 1'($urandom_range(0, 1));
      default: out_ready_a = 1'b0;
    endcase
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    set_rdy();
  endtask

  task automatic send(input int inst, input xv_t x, input bit md, input int g, input int off,
                      input yv_t ey, input logic [3:0] es);
    exp_t e;
    bit   ok = 0;
    e.d = ey; e.s = es; e.lat = (rdy_mode == 0); e.cyc = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(posedge clk); #1;
      set_rdy();
      if (inst == 0) begin
        in_valid_a = 1'b1; in_data_a = x; mode_a = md; gain_a = g[7:0]; offset_a = off[23:0];
        in_valid_b = 1'b0;
      end else begin
        in_valid_b = 1'b1; in_data_b = x; mode_b = md; gain_b = g[7:0]; offset_b = off[15:0];
        in_valid_a = 1'b0;
      end
      @(negedge clk);
      if ((inst == 0) ? in_ready_a : in_ready_b) begin
        e.cyc = cyc;
        if (inst == 0) qa.push_back(e);
        else           qb.push_back(e);
        ok = 1;
      end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: got in_ready low for 200 cycles, expected acceptance");
    end
  endtask

  task automatic send_model(input int inst, input xv_t x, input bit md, input int g, input int off);
    yv_t        ey;
    logic [3:0] es;
    logic [23:0] y;
    logic        s;
    for (int k = 0; k < 4; k++) begin
      model(x[k], md, g, off, (inst == 0) ? 24 : 16, y, s);
      ey[k] = y;
      es[k] = s;
    end
    send(inst, x, md, g, off, ey, es);
  endtask

  task automatic flush();
    int t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 100) begin
      idle();
      t++;
    end
    if (t >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d beats pending, expected 0", qa.size(), qb.size());
    end
    idle();
    idle();
  endtask

  initial begin : mon_a
    exp_t        e;
    logic        hold = 1'b0;
    logic [99:0] hv = '0;
    forever begin
      @(negedge clk);
      if (hold && out_valid_a) check("a_stall_hold", {out_data_a, out_sat_a}, hv);
      if (out_valid_a && out_ready_a) begin
        if (qa.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL a_unexpected: got beat %0h, expected none", out_data_a);
        end else begin
          e = qa.pop_front();
          check("a_beat", {out_data_a, out_sat_a}, {e.d, e.s});
          if (e.lat) check("a_latency", cyc - e.cyc, 3);
        end
      end
      hold = out_valid_a && !out_ready_a;
      hv   = {out_data_a, out_sat_a};
    end
  end

  initial begin : mon_b
    exp_t e;
    yv_t  g;
    forever begin
      @(negedge clk);
      if (out_valid_b && out_ready_b) begin
        for (int k = 0; k < 4; k++) g[k] = 24'(out_data_b[k*16 +: 16]);
        if (qb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected: got beat %0h, expected none", out_data_b);
        end else begin
          e = qb.pop_front();
          check("b_beat", {g, out_sat_b}, {e.d, e.s});
          if (e.lat) check("b_latency", cyc - e.cyc, 3);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    xv_t        x;
    yv_t        ey;
    logic [63:0] r;
    reset = 1'b1;
    in_valid_a = 0; in_data_a = '0; mode_a = 0; gain_a = '0; offset_a = '0; out_ready_a = 1;
    in_valid_b = 0; in_data_b = '0; mode_b = 0; gain_b = '0; offset_b = '0; out_ready_b = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_in_ready", in_ready_a, 1);
    check("rst_out_data", out_data_a, 0);
    check("rst_out_sat", out_sat_a, 0);
    check("rst_b_out_valid", out_valid_b, 0);

    // basic log point
    for (int k = 0; k < 4; k++) begin x[k] = 48'h100; ey[k] = 24'h008000; end
    send(0, x, 0, 16, 0, ey, 4'b0000);
    flush();

    // mantissa, small values and zero, back-to-back
    x[0] = 48'h180; x[1] = 48'h3; x[2] = 48'h1; x[3] = 48'h0;
    ey[0] = 24'd2176; ey[1] = 24'd384; ey[2] = 24'd0; ey[3] = 24'd0;
    send(0, x, 0, 1, 0, ey, 4'b0000);
    ey[0] = 24'd2076; ey[1] = 24'd284; ey[2] = 24'd0; ey[3] = 24'd0;
    send(0, x, 0, 1, 100, ey, 4'b0100);
    x[0] = 48'h8000_0000_0000; x[1] = 48'hFFFF_FFFF_FFFF; x[2] = 48'h100; x[3] = 48'h0;
    ey[0] = 24'h2ED100; ey[1] = 24'h2FCF01; ey[2] = 24'h07F800; ey[3] = 24'h0;
    send(0, x, 0, 255, 0, ey, 4'b0000);
    // bypass, then mode toggling every beat
    x[0] = 48'h1234_5678_9ABC; x[1] = 48'hFFFF_FFFF_FFFF; x[2] = 48'h0; x[3] = 48'h0000_0100_0000;
    ey[0] = 24'h123456; ey[1] = 24'hFFFFFF; ey[2] = 24'h0; ey[3] = 24'h000001;
    send(0, x, 1, 255, 24'hFFFFFF, ey, 4'b0000);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) begin
        x[k]  = 48'h8000_0000_0000;
        ey[k] = (b % 2 == 1) ? 24'h800000 : 24'h002F00;
      end
      send(0, x, b % 2, 1, 0, ey, 4'b0000);
    end
    flush();

    // narrow-output instance: high and low clamps, bypass truncation
    x[0] = 48'h8000_0000_0000; x[1] = 48'h100; x[2] = 48'h1; x[3] = 48'h0;
    ey[0] = 24'hFFFF; ey[1] = 24'hFFFF; ey[2] = 24'h0; ey[3] = 24'h0;
    send(1, x, 0, 255, 0, ey, 4'b0011);
    x[0] = 48'h1; x[1] = 48'h0; x[2] = 48'h180; x[3] = 48'h8000_0000_0000;
    ey[0] = 24'h0; ey[1] = 24'h0; ey[2] = 24'd2076; ey[3] = 24'd11932;
    send(1, x, 0, 1, 100, ey, 4'b0001);
    x[0] = 48'h1234_5678_9ABC; x[1] = 48'h0; x[2] = 48'h0; x[3] = 48'h0;
    ey[0] = 24'h1234; ey[1] = 24'h0; ey[2] = 24'h0; ey[3] = 24'h0;
    send(1, x, 1, 7, 5, ey, 4'b0000);
    flush();

    // random back-to-back traffic with random backpressure
    rdy_mode = 1;
    for (int b = 0; b < 30; b++) begin
      for (int k = 0; k < 4; k++) begin
        r    = {$urandom(), $urandom()};
        x[k] = r[47:0] >> $urandom_range(0, 47);
      end
      if (b % 7 == 3) x[3] = '0;
      send_model(0, x, ($urandom_range(0, 3) == 0), $urandom_range(0, 255), $urandom_range(0, 300000));
    end
    rdy_mode = 0;
    flush();

    // reset with three beats stalled in the pipe
    rdy_mode = 2;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 4; k++) x[k] = 48'h100 << b;
      send_model(0, x, 0, 3, 0);
    end
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    reset = 1'b1;
    qa.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", out_valid_a, 0);
    check("midrst_out_data", out_data_a, 0);
    check("midrst_out_sat", out_sat_a, 0);
    check("midrst_in_ready", in_ready_a, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    rdy_mode = 0;
    repeat (10) idle();
    for (int k = 0; k < 4; k++) begin x[k] = 48'h100; ey[k] = 24'h008000; end
    send(0, x, 0, 16, 0, ey, 4'b0000);
    flush();

    check("queues_empty", qa.size() + qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
